// File: rtl/seq_mult_q15_if.sv
// Handshake and operand/result bundle between the FIR tap sequencer and seq_mult_q15.
//   start   : caller -> multiplier, request strobe (sampled only when idle)
//   a, b    : caller -> multiplier, signed Q1.15 sample and coefficient
//   product : multiplier -> caller, rounded/saturated Q1.15 result
//   busy    : multiplier -> caller, high while a product is being computed
//   done    : multiplier -> caller, one-cycle pulse when product updates
interface seq_mult_q15_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] product;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  product, busy, done
    );

    modport slave (
        input  start, a, b,
        output product, busy, done
    );
endinterface

// File: rtl/seq_mult_q15.sv
// Sequential radix-2 Booth multiplier for signed Q1.15 operands.
// One Booth step per clock, WIDTH steps per product, result rounded (or
// truncated) by FRAC bits and saturated to WIDTH bits. Requires FRAC >= 1.
// Ports:
//   clk30x : system clock
//   rst    : synchronous active-high reset
//   bus    : slave side of seq_mult_q15_if (start/a/b in, product/busy/done out)
module seq_mult_q15 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 15,
    parameter int unsigned ROUND = 1
) (
    input  logic            clk30x,
    input  logic            rst,
    seq_mult_q15_if.slave   bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic signed [PW-1:0] RND_C =
        (ROUND != 0) ? (PW'(1) << (FRAC - 1)) : '0;
    localparam logic signed [PW-1:0] SAT_HI =
        {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO =
        {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic signed [PW-1:0]    acc_q, acc_d;
    logic signed [PW-1:0]    mcand_q, mcand_d;   // a << step, sign-extended
    logic [WIDTH:0]          mplr_q, mplr_d;     // {b, b[-1]=0}, shifted right per step
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        product_q, product_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic signed [PW-1:0]    acc_step;
    logic signed [PW-1:0]    acc_rnd;
    logic signed [PW-1:0]    acc_shr;
    logic [WIDTH-1:0]        acc_sat;

    // Booth recoding of the current bit pair {b[i], b[i-1]}
    always_comb begin
        acc_step = acc_q;
        case (mplr_q[1:0])
            2'b01:   acc_step = acc_q + mcand_q;
            2'b10:   acc_step = acc_q - mcand_q;
            default: acc_step = acc_q;
        endcase
    end

    // Round, rescale and clamp the accumulator value after the current step
    always_comb begin
        acc_rnd = acc_step + RND_C;
        acc_shr = acc_rnd >>> FRAC;
        if (acc_shr > SAT_HI) begin
            acc_sat = SAT_HI[WIDTH-1:0];
        end else if (acc_shr < SAT_LO) begin
            acc_sat = SAT_LO[WIDTH-1:0];
        end else begin
            acc_sat = acc_shr[WIDTH-1:0];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    mcand_d = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
                    mplr_d  = {bus.b, 1'b0};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                acc_d   = acc_step;
                mcand_d = mcand_q <<< 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // Final step: publish the result of this step directly
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = S_IDLE;
                    product_d = acc_sat;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk30x) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_mult_q15.sv
// Directed bench for seq_mult_q15: a rounding instance and a truncating
// instance share the same stimulus; results are compared against
// hand-computed Q1.15 products.
module tb_seq_mult_q15;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;

    int n_checks = 0;
    int n_errors = 0;

    seq_mult_q15_if #(.WIDTH(16)) u_if   ();
    seq_mult_q15_if #(.WIDTH(16)) u_if_t ();

    assign u_if.start   = start;
    assign u_if.a       = a;
    assign u_if.b       = b;
    assign u_if_t.start = start;
    assign u_if_t.a     = a;
    assign u_if_t.b     = b;

    seq_mult_q15 #(.WIDTH(16), .FRAC(15), .ROUND(1)) u_dut (
        .clk30x (clk),
        .rst    (rst),
        .bus    (u_if.slave)
    );

    seq_mult_q15 #(.WIDTH(16), .FRAC(15), .ROUND(0)) u_dut_t (
        .clk30x (clk),
        .rst    (rst),
        .bus    (u_if_t.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated product; optionally pokes start and new operands mid-run
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_r, input logic [15:0] exp_t,
                          input bit poke, input string tag);
        int n;
        int busy_n;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_n = 0;
        while (!u_if.done && n < 60) begin
            if (u_if.busy) busy_n++;
            if (poke && n == 5) begin
                start = 1'b1; a = 16'h7FFF; b = 16'h7FFF;
            end else if (poke && n == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd17);
        check_eq({tag, "_busy_len"}, 32'(busy_n), 32'd16);
        check_eq({tag, "_done_t"}, 32'(u_if_t.done), 32'd1);
        check_eq({tag, "_prod_rnd"}, 32'(u_if.product), 32'(exp_r));
        check_eq({tag, "_prod_trunc"}, 32'(u_if_t.product), 32'(exp_t));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(u_if.done), 32'd0);
        check_eq({tag, "_prod_hold"}, 32'(u_if.product), 32'(exp_r));
    endtask

    initial begin
        int t;
        int dn;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_product", 32'(u_if.product), 32'd0);
        check_eq("rst_busy", 32'(u_if.busy), 32'd0);
        check_eq("rst_done", 32'(u_if.done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_done", 32'(u_if.done), 32'd0);

        run_op(16'h4000, 16'h4000, 16'h2000, 16'h2000, 1'b0, "half_sq");
        run_op(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, "sat_pos");
        run_op(16'h8000, 16'h7FFF, 16'h8001, 16'h8001, 1'b0, "min_max");
        run_op(16'h1999, 16'h03EB, 16'h00C9, 16'h00C8, 1'b0, "round");
        run_op(16'hFB85, 16'h7FFF, 16'hFB85, 16'hFB85, 1'b0, "neg_a");
        run_op(16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, "tiny_neg");
        run_op(16'h4000, 16'hC000, 16'hE000, 16'hE000, 1'b1, "neg_b_poke");

        // Back-to-back: start held high, operands change during each run
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; start = 1'b1;
        @(negedge clk);
        a = 16'h1999; b = 16'h03EB;
        t = 1;
        while (!u_if.done && t < 60) begin
            @(negedge clk);
            t++;
        end
        check_eq("b2b_first_lat", 32'(t), 32'd17);
        check_eq("b2b_first_prod", 32'(u_if.product), 32'h2000);
        @(negedge clk);
        check_eq("b2b_recapture_busy", 32'(u_if.busy), 32'd1);
        a = 16'h8000; b = 16'h8000;
        t = 1;
        while (!u_if.done && t < 60) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check_eq("b2b_interval", 32'(t), 32'd17);
        check_eq("b2b_second_rnd", 32'(u_if.product), 32'h00C9);
        check_eq("b2b_second_trunc", 32'(u_if_t.product), 32'h00C8);
        @(negedge clk);
        check_eq("b2b_stop_busy", 32'(u_if.busy), 32'd0);

        // Reset in the middle of a run aborts without a done pulse
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("abort_busy_before", 32'(u_if.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(u_if.busy), 32'd0);
        check_eq("abort_done", 32'(u_if.done), 32'd0);
        check_eq("abort_product", 32'(u_if.product), 32'd0);
        check_eq("abort_product_t", 32'(u_if_t.product), 32'd0);
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (u_if.done) dn++;
        end
        check_eq("abort_no_done", 32'(dn), 32'd0);

        run_op(16'h8000, 16'h7FFF, 16'h8001, 16'h8001, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
